// File: rtl/alu_ctrl_pkg.sv
// Shared ALU op codes, sequencer state encoding and op classification helpers.
package alu_ctrl_pkg;

  localparam int ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [ALU_OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [ALU_OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [ALU_OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [ALU_OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [ALU_OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [ALU_OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [ALU_OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [ALU_OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [ALU_OP_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [ALU_OP_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [ALU_OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [ALU_OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [ALU_OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [ALU_OP_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [ALU_OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [ALU_OP_W-1:0] OP_ORI  = 5'b10000;
  localparam logic [ALU_OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [ALU_OP_W-1:0] OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_T_Y   = 3'd1,
    ST_T_ALU = 3'd2,
    ST_T_WL  = 3'd3,
    ST_T_WH  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Mul/div produce a 64-bit Z that is written back as LO then HI.
  function automatic logic is_wide_op(input logic [ALU_OP_W-1:0] op_i);
    return (op_i == OP_MUL) || (op_i == OP_DIV);
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary index to one-hot decoder with enable; all-zero output when disabled.
// Combinational, zero latency, no backpressure.
module onehot_dec #(
  parameter int IDX_W = 4,
  parameter int N     = 16
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N-1:0]     dec_o
);

  always_comb begin
    dec_o = '0;
    if (en_i) dec_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Register-register ALU microsequencer: Y-load, ALU, Z writeback, done pulse; outputs change on the falling edge.
// Accept-to-done 4 cycles (5 for mul/div); cmd_ready high only in IDLE, commands offered while busy are ignored.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int RIDX_W = 4,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [RIDX_W-1:0] cmd_ra,
  input  logic [RIDX_W-1:0] cmd_rb,
  input  logic [RIDX_W-1:0] cmd_rc,
  output logic [NREG-1:0]   Rout,
  output logic [NREG-1:0]   Rin,
  output logic              Yin,
  output logic              Zlowin,
  output logic              Zhighin,
  output logic              Zlowout,
  output logic              Zhighout,
  output logic              HIin,
  output logic              LOin,
  output logic [OP_W-1:0]   op,
  output logic              done
);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [RIDX_W-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic              wide_q, wide_d;

  logic              rout_en_d, rin_en_d;
  logic [RIDX_W-1:0] rout_idx_d;
  logic [NREG-1:0]   rout_d, rin_d;
  logic              op_drive_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    wide_d  = wide_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_T_Y;
          op_d    = cmd_op;
          ra_d    = cmd_ra;
          rb_d    = cmd_rb;
          rc_d    = cmd_rc;
          wide_d  = is_wide_op(cmd_op);
        end
      end
      ST_T_Y:   state_d = ST_T_ALU;
      ST_T_ALU: state_d = ST_T_WL;
      ST_T_WL:  state_d = wide_q ? ST_T_WH : ST_DONE;
      ST_T_WH:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    rout_en_d  = (state_d == ST_T_Y) || (state_d == ST_T_ALU);
    rout_idx_d = (state_d == ST_T_Y) ? rb_d : rc_d;
    rin_en_d   = (state_d == ST_T_WL) && !wide_d;
    op_drive_d = (state_d == ST_T_Y) || (state_d == ST_T_ALU) ||
                 (state_d == ST_T_WL) || (state_d == ST_T_WH);
  end

  onehot_dec #(.IDX_W(RIDX_W), .N(NREG)) u_rout_dec (
    .idx_i (rout_idx_d),
    .en_i  (rout_en_d),
    .dec_o (rout_d)
  );

  onehot_dec #(.IDX_W(RIDX_W), .N(NREG)) u_rin_dec (
    .idx_i (ra_d),
    .en_i  (rin_en_d),
    .dec_o (rin_d)
  );

  always_ff @(negedge Clock or posedge clear) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      wide_q    <= 1'b0;
      cmd_ready <= 1'b1;
      Rout      <= '0;
      Rin       <= '0;
      Yin       <= 1'b0;
      Zlowin    <= 1'b0;
      Zhighin   <= 1'b0;
      Zlowout   <= 1'b0;
      Zhighout  <= 1'b0;
      HIin      <= 1'b0;
      LOin      <= 1'b0;
      op        <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      wide_q    <= wide_d;
      cmd_ready <= (state_d == ST_IDLE);
      Rout      <= rout_d;
      Rin       <= rin_d;
      Yin       <= (state_d == ST_T_Y);
      Zlowin    <= (state_d == ST_T_ALU);
      Zhighin   <= (state_d == ST_T_ALU);
      Zlowout   <= (state_d == ST_T_WL);
      LOin      <= (state_d == ST_T_WL) && wide_d;
      Zhighout  <= (state_d == ST_T_WH);
      HIin      <= (state_d == ST_T_WH);
      op        <= op_drive_d ? op_d : '0;
      done      <= (state_d == ST_DONE);
    end
  end

endmodule
